// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit on the producer side of the fetch/decode
// boundary. It holds the PC and keeps at most one instruction memory request
// in flight. Each fetched instruction is handed to IF/ID over valid/ready,
// tagged with its PC. A redirect from execute overrides the PC. It also
// squashes any fetch that is in flight or held at the output.
module ifu_fetch #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     Inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [31:0]     NOP_INST   = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(64'd4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(64'd3));

   state_t            state_r;
   state_t            state_s;
   logic [XLEN-1:0]   pc_r;
   logic [XLEN-1:0]   pc_s;
   logic              drop_r;
   logic              drop_s;
   logic              inst_valid_r;
   logic              inst_valid_s;
   logic [31:0]       inst_r;
   logic [31:0]       inst_s;
   logic [XLEN-1:0]   inst_pc_r;
   logic [XLEN-1:0]   inst_pc_s;
   logic [XLEN-1:0]   redirect_target_s;

   assign redirect_target_s = redirect_pc & ALIGN_MASK;

   // State and datapath registers; async reset returns everything to the post-reset fetch point.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         pc_r         <= RESET_PC;
         drop_r       <= 1'b0;
         inst_valid_r <= 1'b0;
         inst_r       <= NOP_INST;
         inst_pc_r    <= '0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         drop_r       <= drop_s;
         inst_valid_r <= inst_valid_s;
         inst_r       <= inst_s;
         inst_pc_r    <= inst_pc_s;
      end
   end

   // Next-state logic; a redirect outranks every normal transition.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      drop_s       = drop_r;
      inst_valid_s = inst_valid_r;
      inst_s       = inst_r;
      inst_pc_s    = inst_pc_r;
      if (redirect_valid) begin
         pc_s         = redirect_target_s;
         inst_valid_s = 1'b0;
         case (state_r)
            ST_IDLE: begin
               state_s = ST_REQ;
            end
            ST_HOLD: begin
               // Held instruction is discarded even if decode accepts it this cycle.
               state_s = ST_REQ;
            end
            ST_REQ: begin
               if (imem_req_ready) begin
                  // The old-PC request was accepted; its response must be thrown away.
                  state_s = ST_WAIT;
                  drop_s  = 1'b1;
               end else begin
                  state_s = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  state_s = ST_REQ;
                  drop_s  = 1'b0;
               end else begin
                  state_s = ST_WAIT;
                  drop_s  = 1'b1;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_REQ;
            end
            ST_REQ: begin
               if (imem_req_ready) begin
                  state_s = ST_WAIT;
               end else begin
                  state_s = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop_r) begin
                     drop_s  = 1'b0;
                     state_s = ST_REQ;
                  end else begin
                     inst_s       = imem_rsp_data;
                     inst_pc_s    = pc_r;
                     pc_s         = pc_r + PC_STEP;
                     inst_valid_s = 1'b1;
                     state_s      = ST_HOLD;
                  end
               end else begin
                  state_s = ST_WAIT;
               end
            end
            ST_HOLD: begin
               if (inst_ready) begin
                  inst_valid_s = 1'b0;
                  state_s      = ST_REQ;
               end else begin
                  state_s = ST_HOLD;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   assign imem_req_valid = (state_r == ST_REQ);
   assign imem_req_addr  = pc_r;
   assign inst_valid     = inst_valid_r;
   assign Inst           = inst_r;
   assign inst_pc        = inst_pc_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch. Inputs are driven and outputs are checked on the
// falling clock edge. A second instance with RESET_PC at the top of the address
// space shares all inputs, so it can be used to check PC wrap-around.
module tb_ifu_fetch;

   localparam int XLEN = 64;

   logic            clk;
   logic            rst;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            inst_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            inst_valid;
   logic [31:0]     Inst;
   logic [XLEN-1:0] inst_pc;

   logic            w_req_valid;
   logic [XLEN-1:0] w_req_addr;
   logic            w_inst_valid;
   logic [31:0]     w_inst;
   logic [XLEN-1:0] w_inst_pc;

   int checks   = 0;
   int failures = 0;

   ifu_fetch #(.XLEN(XLEN), .RESET_PC(64'h0000_0000_8000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .Inst(Inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   ifu_fetch #(.XLEN(XLEN), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst),
      .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(w_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(w_inst_valid),
      .inst_ready(inst_ready), .Inst(w_inst), .inst_pc(w_inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0; inst_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 64'h0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || Inst !== 32'h0000_0013 ||
          inst_pc !== 64'h0 || imem_req_addr !== 64'h8000_0000) begin
         failures++;
         $display("FAIL reset_state: req_valid=%b inst_valid=%b Inst=%h inst_pc=%h addr=%h, required 0 0 00000013 0 80000000",
                  imem_req_valid, inst_valid, Inst, inst_pc, imem_req_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
         failures++;
         $display("FAIL first_req: req_valid=%b addr=%h, required 1 80000000", imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL wait_state: req_valid=%b inst_valid=%b, required 0 0", imem_req_valid, inst_valid);
      end
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0513;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || Inst !== 32'h0000_0513 || inst_pc !== 64'h8000_0000 ||
          imem_req_addr !== 64'h8000_0004 || imem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL first_inst: inst_valid=%b Inst=%h inst_pc=%h addr=%h req_valid=%b, required 1 00000513 80000000 80000004 0",
                  inst_valid, Inst, inst_pc, imem_req_addr, imem_req_valid);
      end
   endtask

   task automatic test_wrap();
      checks++;
      if (w_inst_valid !== 1'b1 || w_inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_req_addr !== 64'h0) begin
         failures++;
         $display("FAIL pc_wrap: inst_valid=%b inst_pc=%h next_addr=%h, required 1 fffffffffffffffc 0",
                  w_inst_valid, w_inst_pc, w_req_addr);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b1 || Inst !== 32'h0000_0513 || inst_pc !== 64'h8000_0000 ||
             imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable[%0d]: inst_valid=%b Inst=%h inst_pc=%h req_valid=%b, required 1 00000513 80000000 0",
                     i, inst_valid, Inst, inst_pc, imem_req_valid);
         end
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin
         failures++;
         $display("FAIL hold_release: inst_valid=%b req_valid=%b addr=%h, required 0 1 80000004",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      checks++;
      if (w_req_valid !== 1'b1 || w_req_addr !== 64'h0) begin
         failures++;
         $display("FAIL wrap_second_req: req_valid=%b addr=%h, required 1 0", w_req_valid, w_req_addr);
      end
   endtask

   task automatic test_redirect_wait();
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h8000_1000) begin
         failures++;
         $display("FAIL redir_wait_pc: req_valid=%b addr=%h, required 0 80001000", imem_req_valid, imem_req_addr);
      end
      @(negedge clk);
      @(negedge clk);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
         failures++;
         $display("FAIL redir_wait_drop: inst_valid=%b req_valid=%b addr=%h, required 0 1 80001000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || Inst !== 32'h0010_0093 || inst_pc !== 64'h8000_1000 ||
          imem_req_addr !== 64'h8000_1004) begin
         failures++;
         $display("FAIL redir_wait_deliver: inst_valid=%b Inst=%h inst_pc=%h addr=%h, required 1 00100093 80001000 80001004",
                  inst_valid, Inst, inst_pc, imem_req_addr);
      end
   endtask

   task automatic test_redirect_coincident();
      inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
      @(negedge clk);
      inst_ready = 1'b0; redirect_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin
         failures++;
         $display("FAIL redir_hold: inst_valid=%b req_valid=%b addr=%h, required 0 1 80002000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
      @(negedge clk);
      imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_3000) begin
         failures++;
         $display("FAIL redir_rsp: inst_valid=%b req_valid=%b addr=%h, required 0 1 80003000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || Inst !== 32'h2222_2222 || inst_pc !== 64'h8000_3000) begin
         failures++;
         $display("FAIL redir_rsp_next: inst_valid=%b Inst=%h inst_pc=%h, required 1 22222222 80003000",
                  inst_valid, Inst, inst_pc);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   task automatic test_redirect_req();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_4003;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_4000) begin
         failures++;
         $display("FAIL redir_req_stall: req_valid=%b addr=%h, required 1 80004000", imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_5000;
      @(negedge clk);
      imem_req_ready = 1'b0; redirect_valid = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_3333;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_5000) begin
         failures++;
         $display("FAIL redir_req_accept: inst_valid=%b req_valid=%b addr=%h, required 0 1 80005000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_reset_mid();
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || Inst !== 32'h0000_0013 ||
          inst_pc !== 64'h0 || imem_req_addr !== 64'h8000_0000) begin
         failures++;
         $display("FAIL async_reset: req_valid=%b inst_valid=%b Inst=%h inst_pc=%h addr=%h, required 0 0 00000013 0 80000000",
                  imem_req_valid, inst_valid, Inst, inst_pc, imem_req_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_4444;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
         failures++;
         $display("FAIL late_rsp_ignored: inst_valid=%b req_valid=%b addr=%h, required 0 1 80000000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || Inst !== 32'h0000_0013) begin
         failures++;
         $display("FAIL late_rsp_quiet: inst_valid=%b Inst=%h, required 0 00000013", inst_valid, Inst);
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_hold();
      test_redirect_wait();
      test_redirect_coincident();
      test_redirect_req();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
